// File: rtl/regulation_loop_sequencer.sv
// Start-up / shutdown sequencer for the regulation loop: filters ok_regulation, walks the loop
// through enable, settle and driver release, and latches a fault code on timeout or loss.
module regulation_loop_sequencer #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned OK_FILTER      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned OFF_DELAY      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic       ok_regulation,
  input  logic [4:0] tmi,
  output logic       enable_regulation,
  output logic       go_driver,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  if (OK_FILTER == 0 || 64'(OK_FILTER) > CntRange ||
      TIMEOUT_CYCLES == 0 || 64'(TIMEOUT_CYCLES) > CntRange ||
      SETTLE_CYCLES == 0 || 64'(SETTLE_CYCLES) > CntRange ||
      OFF_DELAY == 0 || 64'(OFF_DELAY) > CntRange) begin : gen_param_check
    $error("regulation_loop_sequencer: cycle parameter does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] FiltLast    = CNT_W'(OK_FILTER - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OffLast     = CNT_W'(OFF_DELAY - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitOk   = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3,
    StShutdown = 3'd4,
    StFault    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             en_q, en_d, go_q, go_d, busy_q, busy_d, fault_q, fault_d;
  logic [1:0]       ok_sync_q;
  logic [CNT_W-1:0] filt_cnt_q;
  logic             ok_filt_q;
  logic             cnt_clr;
  logic             unused_tmi;

  assign unused_tmi = ^tmi[3:2];

  // Symmetric filter: ok_filt flips only after OK_FILTER consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_sync_q  <= 2'b00;
      filt_cnt_q <= '0;
      ok_filt_q  <= 1'b0;
    end else begin
      ok_sync_q <= {ok_sync_q[0], ok_regulation};
      if (ok_sync_q[1] != ok_filt_q) begin
        if (filt_cnt_q == FiltLast) begin
          ok_filt_q  <= ok_sync_q[1];
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_clr = 1'b0;
    if (tmi[4]) begin
      state_d = StIdle;
      code_d  = 2'd0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: if (start && !stop) state_d = StWaitOk;
        StWaitOk: begin
          if (stop) state_d = StIdle;
          else if (ok_filt_q) state_d = StSettle;
          else if (cnt_q == TimeoutLast) begin
            state_d = StFault;
            code_d  = 2'd1;
          end
        end
        StSettle: begin
          if (stop) state_d = StIdle;
          else if (!ok_filt_q) begin
            state_d = StFault;
            code_d  = 2'd2;
          end else if (cnt_q == SettleLast) state_d = StRun;
        end
        StRun: begin
          if (stop || !start) state_d = StShutdown;
          else if (!ok_filt_q) begin
            state_d = StFault;
            code_d  = 2'd3;
          end
        end
        StShutdown: if (cnt_q == OffLast) state_d = StIdle;
        StFault: begin
          if (clear_fault) begin
            state_d = StIdle;
            code_d  = 2'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Outputs decode the next state so they register in step with the state flops.
  always_comb begin
    en_d    = (state_d == StWaitOk) || (state_d == StSettle) ||
              (state_d == StRun) || (state_d == StShutdown);
    go_d    = (state_d == StRun);
    busy_d  = (state_d != StIdle) && (state_d != StFault);
    fault_d = (state_d == StFault);
    if (tmi[4]) begin
      en_d    = tmi[0];
      go_d    = tmi[0] & tmi[1];
      busy_d  = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= 2'd0;
      en_q    <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      en_q    <= en_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign enable_regulation = en_q;
  assign go_driver         = go_q;
  assign busy              = busy_q;
  assign fault             = fault_q;
  assign fault_code        = code_q;
  assign state             = state_q;

endmodule

// File: tb/tb_regulation_loop_sequencer.sv
// Bench for regulation_loop_sequencer: a vector table of cycle-counted steps, plus hand-built
// asynchronous-reset sequences, all checked through an expected-value queue.
module tb_regulation_loop_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear_fault, ok_regulation;
  logic [4:0] tmi;
  logic       enable_regulation, go_driver, busy, fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  regulation_loop_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .stop              (stop),
    .clear_fault       (clear_fault),
    .ok_regulation     (ok_regulation),
    .tmi               (tmi),
    .enable_regulation (enable_regulation),
    .go_driver         (go_driver),
    .busy              (busy),
    .fault             (fault),
    .fault_code        (fault_code),
    .state             (state)
  );

  always #5 clk = ~clk;

  // Packed as {state, enable, go, busy, fault, code}.
  localparam logic [8:0] EIdle   = 9'b000_0_0_0_0_00;
  localparam logic [8:0] EWait   = 9'b001_1_0_1_0_00;
  localparam logic [8:0] ESettle = 9'b010_1_0_1_0_00;
  localparam logic [8:0] ERun    = 9'b011_1_1_1_0_00;
  localparam logic [8:0] EShut   = 9'b100_1_0_1_0_00;
  localparam logic [8:0] EF1     = 9'b101_0_0_0_1_01;
  localparam logic [8:0] EF2     = 9'b101_0_0_0_1_10;
  localparam logic [8:0] EF3     = 9'b101_0_0_0_1_11;
  localparam logic [8:0] EOvrGo  = 9'b000_1_1_0_0_00;
  localparam logic [8:0] EOvrEn  = 9'b000_1_0_0_0_00;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       clr;
    logic       ok;
    logic [4:0] tmi;
    int         cycles;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb_q[$];
  string      sb_name_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic add(input string n, input logic st, input logic sp, input logic cl,
                     input logic ok, input logic [4:0] t, input int cyc, input logic [8:0] e);
    vec_t v;
    v.name = n; v.start = st; v.stop = sp; v.clr = cl; v.ok = ok;
    v.tmi = t; v.cycles = cyc; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    logic [8:0] exp;
    logic [8:0] act;
    string      n;
    exp = sb_q.pop_front();
    n   = sb_name_q.pop_front();
    act = {state, enable_regulation, go_driver, busy, fault, fault_code};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d en=%b go=%b busy=%b flt=%b code=%0d, want st=%0d en=%b go=%b busy=%b flt=%b code=%0d",
               n, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
               exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    start = v.start; stop = v.stop; clear_fault = v.clr;
    ok_regulation = v.ok; tmi = v.tmi;
    sb_q.push_back(v.exp);
    sb_name_q.push_back(v.name);
    repeat (v.cycles) @(negedge clk);
    check_out();
  endtask

  task automatic step(input string n, input logic st, input logic sp, input logic ok,
                      input int cyc, input logic [8:0] e);
    vec_t v;
    v.name = n; v.start = st; v.stop = sp; v.clr = 1'b0; v.ok = ok;
    v.tmi = 5'b0; v.cycles = cyc; v.exp = e;
    apply(v);
  endtask

  // Assert reset between clock edges; outputs must clear without waiting for a clock.
  task automatic reset_check(input string n);
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(EIdle);
    sb_name_q.push_back(n);
    check_out();
    start = 1'b0; stop = 1'b0; clear_fault = 1'b0; ok_regulation = 1'b0; tmi = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; clear_fault = 1'b0; ok_regulation = 1'b0; tmi = 5'b0;

    // Nominal start-up, pin rises at cycle 10
    add("nom_wait_c1",   1, 0, 0, 0, 5'b0,   1, EWait);
    add("nom_wait_c10",  1, 0, 0, 0, 5'b0,   9, EWait);
    add("nom_filt_lat",  1, 0, 0, 1, 5'b0,   6, EWait);
    add("nom_settle",    1, 0, 0, 1, 5'b0,   1, ESettle);
    add("nom_settle_63", 1, 0, 0, 1, 5'b0,  63, ESettle);
    add("nom_run",       1, 0, 0, 1, 5'b0,   1, ERun);
    // Glitch rejection, then real loss in RUN
    add("glitch3",       1, 0, 0, 0, 5'b0,   3, ERun);
    add("glitch3_after", 1, 0, 0, 1, 5'b0,  10, ERun);
    add("loss_pre",      1, 0, 0, 0, 5'b0,   6, ERun);
    add("loss_fault3",   1, 0, 0, 0, 5'b0,   1, EF3);
    add("clear_f3",      0, 0, 1, 1, 5'b0,   1, EIdle);
    add("clear_in_idle", 0, 0, 1, 1, 5'b0,   1, EIdle);
    add("idle_settle",   0, 0, 0, 0, 5'b0,   8, EIdle);
    // Start-up timeout
    add("to_wait",       1, 0, 0, 0, 5'b0,   1, EWait);
    add("to_wait_999",   1, 0, 0, 0, 5'b0, 999, EWait);
    add("to_fault1",     1, 0, 0, 0, 5'b0,   1, EF1);
    add("fault_ignores", 1, 1, 0, 0, 5'b0,   5, EF1);
    add("clear_f1",      0, 0, 1, 0, 5'b0,   1, EIdle);
    // Stop from RUN
    add("sd_wait",       1, 0, 0, 1, 5'b0,   1, EWait);
    add("sd_settle",     1, 0, 0, 1, 5'b0,   6, ESettle);
    add("sd_run",        1, 0, 0, 1, 5'b0,  64, ERun);
    add("sd_go_off",     1, 1, 0, 1, 5'b0,   1, EShut);
    add("sd_hold_7",     1, 1, 0, 1, 5'b0,   7, EShut);
    add("sd_idle",       1, 1, 0, 1, 5'b0,   1, EIdle);
    add("stop_wins",     1, 1, 0, 1, 5'b0,   3, EIdle);
    // Stop coinciding with filtered loss
    add("sl_wait",       1, 0, 0, 1, 5'b0,   1, EWait);
    add("sl_settle",     1, 0, 0, 1, 5'b0,   1, ESettle);
    add("sl_settle_63",  1, 0, 0, 1, 5'b0,  63, ESettle);
    add("sl_run",        1, 0, 0, 1, 5'b0,   1, ERun);
    add("sl_loss_pre",   1, 0, 0, 0, 5'b0,   6, ERun);
    add("sl_stop_wins",  1, 1, 0, 0, 5'b0,   1, EShut);
    add("sl_idle",       1, 1, 0, 0, 5'b0,   8, EIdle);
    // Test-mode override from RUN
    add("ov_settle",     1, 0, 0, 1, 5'b0,   7, ESettle);
    add("ov_run",        1, 0, 0, 1, 5'b0,  64, ERun);
    add("ov_go",         1, 0, 0, 1, 5'b10011, 1, EOvrGo);
    add("ov_en_only",    1, 0, 0, 1, 5'b10001, 1, EOvrEn);
    add("ov_all_off",    0, 0, 0, 1, 5'b10000, 1, EIdle);
    add("ov_release",    0, 0, 0, 1, 5'b00000, 2, EIdle);
    add("tmi_low_ign",   0, 0, 0, 1, 5'b01111, 2, EIdle);

    @(negedge clk);
    sb_q.push_back(EIdle);
    sb_name_q.push_back("reset_state");
    check_out();
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset in SETTLE, then restart into a SETTLE loss fault and reset again
    step("rs_wait",    1, 0, 1, 1, EWait);
    step("rs_settle",  1, 0, 1, 6, ESettle);
    reset_check("rst_in_settle");
    step("rs2_wait",   1, 0, 1, 1, EWait);
    step("rs2_settle", 1, 0, 1, 6, ESettle);
    step("rs2_pre",    1, 0, 0, 6, ESettle);
    step("rs2_fault2", 1, 0, 0, 1, EF2);
    reset_check("rst_in_fault");
    step("rs3_idle",   0, 0, 0, 3, EIdle);
    step("rs3_wait",   1, 0, 1, 1, EWait);
    step("rs3_settle", 1, 0, 1, 6, ESettle);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
